// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock through a single full-adder cell, LSB first.
// done pulses WIDTH+1 edges after start is sampled; start while busy is ignored.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] ss_q, ss_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH:0]   ss_cat;

  fa u_fa (
    .a  (xs_q[0]),
    .b  (ys_q[0]),
    .ci (c_q),
    .s  (fa_sum),
    .co (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    ss_d    = ss_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    ss_cat  = {fa_sum, ss_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          state_d = S_RUN;
          xs_d    = x;
          ys_d    = y;
          c_d     = cin;
          ss_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        ss_d  = ss_cat[WIDTH:1];
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          sum_d   = ss_cat[WIDTH:1];
          cout_d  = fa_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      ss_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      ss_q    <= ss_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] x, y;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1, x1, y1, cin1;
  logic       busy1, done1, sum1, cout1;

  int n_chk  = 0;
  int n_pass = 0;

  int  prev_sum  = 0;
  int  prev_cout = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Called at a negedge with the 8-bit DUT idle or in its done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit inject, input bit keep);
    int r;
    r = int'(a) + int'(b) + int'(c);
    x = a; y = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = keep;
    x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_sum_hold", sum, prev_sum);
      check("run_cout_hold", cout, prev_cout);
      if (inject && k == 2) begin
        start = 1'b1; x = 8'hAA; y = 8'h55; cin = 1'($urandom);
      end else if (inject && k == 3) begin
        start = keep;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("result_sum", sum, r % 256);
    check("result_cout", cout, r / 256);
    prev_sum  = r % 256;
    prev_cout = r / 256;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_sum", sum, prev_sum);
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int r;
    r = int'(a) + int'(b) + int'(c);
    x1 = a; y1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; x1 = ~a; y1 = ~b; cin1 = ~c;
    @(negedge clk);
    check("w1_busy", busy1, 1);
    check("w1_run_done", done1, 0);
    @(negedge clk);
    check("w1_done", done1, 1);
    check("w1_done_busy", busy1, 0);
    check("w1_sum", sum1, r % 2);
    check("w1_cout", cout1, r / 2);
    @(negedge clk);
    check("w1_done_end", done1, 0);
  endtask

  initial begin
    int seen;
    bit keep;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    start1 = 1'b0; x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_w1_busy", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0); idle(2);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); idle(1);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); idle(1);
    op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0); idle(3);
    op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(8'h02, 8'h02, 1'b0, 1'b0, 1'b0); idle(1);

    // Reset in the middle of an operation.
    op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0); idle(1);
    x = 8'h80; y = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    prev_sum = 0; prev_cout = 0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    op8(8'h03, 8'h04, 1'b0, 1'b0, 1'b0); idle(1);

    for (int i = 0; i < 20; i++) begin
      keep = 1'($urandom);
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), keep);
      if (!keep && $urandom_range(1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that sits directly upstream of the FA full-adder cell and drives it.
- Loads two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock into a single FA instance, LSB first.
- Registers FA cout as the next cycle's cin and shifts the FA sum bit into a result register.
- Area-cheap alternative to a WIDTH-wide ripple adder, used wherever throughput is not critical.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when the block is idle or in its done cycle.
- x  input  WIDTH  operand A; sampled with start.
- y  input  WIDTH  operand B; sampled with start.
- cin  input  1  initial carry; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum/cout are newly valid.
- sum  output  WIDTH  registered result (x+y+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and bit counter cleared.
- Reset mid-operation aborts the operation. No done pulse. The old result is lost (cleared to 0).
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0: load x->xs, y->ys, cin->c; cnt=0; go RUN. busy=1 after E0.
  - start=0: stay in IDLE.
- RUN:
  - Each edge E1..E_WIDTH: FA inputs are x=xs[0], y=ys[0], cin=c.
  - ss <= {fa_sum, ss[WIDTH-1:1]}; xs, ys shift right by 1 (zero fill); c <= fa_cout; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH): sum <= final ss value including this bit; cout <= fa_cout; go DONE.
- DONE: lasts one cycle (after E_WIDTH). busy=0, done=1. Next edge returns to IDLE, or to RUN if start=1.
- Latency: done is high during the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after the start sample.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high together.
- start while busy=1 is ignored; operands are not re-sampled and the current operation is unaffected.
- start in the DONE cycle is accepted. The done pulse still ends after one cycle, and busy rises the following cycle.
- sum/cout hold the previous result throughout RUN and update only at E_WIDTH. They then hold until the next completion or reset.
- Changes to x/y/cin after the sample edge have no effect.
- WIDTH=1: RUN lasts exactly one edge; done at E2 relative to E0+1 as per the general rule.
- cnt width is clog2(WIDTH)+1; it must not wrap before WIDTH.
- All outputs are driven from registers; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, x=0x5A, y=0x3C, cin=0, start pulsed 1 cycle -> busy high 8 cycles, done pulse on 9th cycle after start edge, sum=0x96, cout=0.
- x=0xFF, y=0x01, cin=0 -> sum=0x00, cout=1; then x=0xFF, y=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x10+0x20, then at cycle 3 of RUN pulse start with x=0xAA, y=0x55 -> ignored; result sum=0x30, cout=0, single done pulse.
- Hold start=1 continuously with operands 0x01+0x01, then 0x02+0x02 presented at the done cycle -> done pulses every 9 cycles; results 0x02 then 0x04; sum holds 0x02 during the second RUN.
- Complete 0x0F+0x01 (sum=0x10), start 0x80+0x80, assert rst at RUN cycle 4 -> immediately busy=0, done=0, sum=0, cout=0. No done afterwards. A fresh 0x03+0x04 after reset release gives 0x07.
- WIDTH=1 build: x=1, y=1, cin=1 -> sum=1, cout=1, done two edges after the start edge.
